is_uart_tx: RTL

- UART serial transmitter, directly downstream of the top-level controller (debounced button events, clock divider, reset sync).
- Accepts one parallel word per valid/ready handshake and serialises it on the TX line as a standard asynchronous frame: start, data LSB-first, optional parity, stop bit(s).
- Generates its own bit timing from the system clock.
- Drives the board UART TX pin.

---
 rtl/is_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/is_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : is_uart_tx
//  Brief    : UART transmitter, valid/ready word in, start/data/parity/stop out
//  Revision : 1.0 - initial release
// ============================================================================
module is_uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_o,
    output logic              tx_busy_o,
    output logic              tx_done_o
);

    localparam int c_clks_per_bit = CLK_FREQ_HZ / BAUD;
    localparam int c_tmr_w        = (c_clks_per_bit > 2) ? $clog2(c_clks_per_bit) : 1;
    localparam int c_idx_w        = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [c_tmr_w-1:0] c_last_tick = c_tmr_w'(c_clks_per_bit - 1);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_W - 1);
    localparam logic               c_par_odd   = (PARITY_ODD != 0);

    generate
        if (c_clks_per_bit < 2) begin : g_err_clks_per_bit
            $error("is_uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop_bits
            $error("is_uart_tx: STOP_BITS must be 1 or 2");
        end
        if (DATA_W < 5 || DATA_W > 9) begin : g_err_data_w
            $error("is_uart_tx: DATA_W must be in 5..9");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_tmr_w-1:0]  r_timer;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_stop_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parity;
    logic                r_tx;
    logic                r_ready;
    logic                r_done;
    logic                w_bit_end;

    assign w_bit_end = (r_timer == c_last_tick);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    if (tx_valid_i && r_ready) begin
                        r_shift    <= tx_data_i;
                        r_parity   <= (^tx_data_i) ^ c_par_odd;
                        r_timer    <= '0;
                        r_idx      <= '0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        case (r_state)
                            S_START: begin
                                r_tx    <= r_shift[0];
                                r_shift <= r_shift >> 1;
                                r_state <= S_DATA;
                            end
                            S_DATA: begin
                                if (r_idx == c_last_idx) begin
                                    if (PARITY_EN != 0) begin
                                        r_tx    <= r_parity;
                                        r_state <= S_PARITY;
                                    end else begin
                                        r_tx    <= 1'b1;
                                        r_state <= S_STOP;
                                    end
                                end else begin
                                    // shift register always holds the next bit in position 0
                                    r_idx   <= r_idx + c_idx_w'(1);
                                    r_tx    <= r_shift[0];
                                    r_shift <= r_shift >> 1;
                                end
                            end
                            S_PARITY: begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                            S_STOP: begin
                                if (STOP_BITS == 2 && !r_stop_idx) begin
                                    r_stop_idx <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_ready <= 1'b1;
                                    r_done  <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                                r_ready <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
            endcase
        end
    end

    assign tx_o       = r_tx;
    assign tx_ready_o = r_ready;
    assign tx_busy_o  = ~r_ready;
    assign tx_done_o  = r_done;

endmodule
`default_nettype wire
